// File: rtl/col_seq_pkg.sv
// Shared op/status codes, FSM state type and default timing for the column pulse sequencer.
package col_seq_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [1:0] STAT_OK    = 2'b00;
  localparam logic [1:0] STAT_ABORT = 2'b01;
  localparam logic [1:0] STAT_ILL   = 2'b10;

  localparam int DEF_PRE_CYC  = 4;
  localparam int DEF_DEAD_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DEAD1,
    S_PULSE,
    S_DEAD2,
    S_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/col_seq_timer.sv
// Countdown timer: load N-1 on entry to a timed phase, zero flag marks the phase's last cycle.
module col_seq_timer #(
  parameter int TW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/col_pulse_seq.sv
// Column pulse sequencer: precharge, break-before-make dead time, op pulse, dead time, done strobe.
// Optional macro COL_PULSE_REPEAT_EN adds cmd_reps to repeat the pulse sequence reps+1 times.
module col_pulse_seq
  import col_seq_pkg::*;
#(
  parameter int W        = 8,
  parameter int PRE_CYC  = DEF_PRE_CYC,
  parameter int DEAD_CYC = DEF_DEAD_CYC
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_width,
`ifdef COL_PULSE_REPEAT_EN
  input  logic [3:0]   cmd_reps,
`endif
  input  logic         abort,
  output logic         sw_ref,
  output logic         sw_c_plus,
  output logic         sw_c_minus,
  output logic         busy,
  output logic         done,
  output logic [1:0]   status
);

  localparam int TW = max3(W, $clog2(PRE_CYC + 1), $clog2(DEAD_CYC + 1));

  state_t        r_state;
  state_t        w_nxt;
  logic [1:0]    r_op;
  logic [W-1:0]  r_width;
  logic          r_abrt;
  logic          w_abrt_take;
  logic          w_more;
  logic          w_tmr_zero;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic [TW-1:0] w_wid_m1;

`ifdef COL_PULSE_REPEAT_EN
  logic [3:0]    r_reps_left;
  assign w_more = (r_reps_left != 4'd0) && !r_abrt;
`else
  assign w_more = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE);
  // A zero width still yields a one-cycle pulse.
  assign w_wid_m1  = (r_width == '0) ? '0 : (TW'(r_width) - TW'(1));

  always_comb begin
    w_nxt       = r_state;
    w_abrt_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_ILL)       w_nxt = S_DONE;
          else if (cmd_op == OP_READ) w_nxt = S_DEAD1;
          else                        w_nxt = S_PRE;
        end
      end
      S_PRE, S_DEAD1, S_PULSE: begin
        if (abort) begin
          w_nxt       = S_DEAD2;
          w_abrt_take = 1'b1;
        end else if (w_tmr_zero) begin
          case (r_state)
            S_PRE:   w_nxt = S_DEAD1;
            S_DEAD1: w_nxt = S_PULSE;
            default: w_nxt = S_DEAD2;
          endcase
        end
      end
      S_DEAD2: begin
        if (w_tmr_zero) begin
          if (!w_more)                w_nxt = S_DONE;
          else if (r_op == OP_READ)   w_nxt = S_DEAD1;
          else                        w_nxt = S_PRE;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Timer reloads on every state change, so its zero flag always refers to the current phase.
  always_comb begin
    w_tmr_load = (w_nxt != r_state);
    case (w_nxt)
      S_PRE:            w_tmr_val = TW'(PRE_CYC - 1);
      S_PULSE:          w_tmr_val = w_wid_m1;
      S_DEAD1, S_DEAD2: w_tmr_val = TW'(DEAD_CYC - 1);
      default:          w_tmr_val = '0;
    endcase
  end

  col_seq_timer #(.TW(TW)) u_timer (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (!w_tmr_load),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge wb_clk_i) begin
    if (r_state == S_IDLE && cmd_valid) begin
      r_op    <= cmd_op;
      r_width <= cmd_width;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_abrt     <= 1'b0;
      sw_ref     <= 1'b0;
      sw_c_plus  <= 1'b0;
      sw_c_minus <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= STAT_OK;
`ifdef COL_PULSE_REPEAT_EN
      r_reps_left <= 4'd0;
`endif
    end else begin
      r_state    <= w_nxt;
      busy       <= (w_nxt != S_IDLE);
      done       <= (w_nxt == S_DONE);
      sw_ref     <= (w_nxt == S_PRE) || ((w_nxt == S_PULSE) && (r_op == OP_READ));
      sw_c_plus  <= (w_nxt == S_PULSE) && (r_op == OP_SET);
      sw_c_minus <= (w_nxt == S_PULSE) && (r_op == OP_RESET);
      status     <= STAT_OK;
      if (w_nxt == S_DONE) begin
        if (r_state == S_IDLE) status <= STAT_ILL;
        else if (r_abrt)       status <= STAT_ABORT;
      end
      if (w_abrt_take) r_abrt <= 1'b1;
      if (r_state == S_IDLE && cmd_valid) begin
        r_abrt <= 1'b0;
`ifdef COL_PULSE_REPEAT_EN
        r_reps_left <= cmd_reps;
`endif
      end
`ifdef COL_PULSE_REPEAT_EN
      if (r_state == S_DEAD2 && w_tmr_zero && w_more) r_reps_left <= r_reps_left - 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_col_pulse_seq.sv
// Bench for col_pulse_seq: directed scenarios plus randomized commands against a phase-list model.
module tb_col_pulse_seq;

  localparam int W    = 8;
  localparam int PRE  = 4;
  localparam int DEAD = 2;
  localparam int MAXC = 1200;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_width;
  logic         abort;
  logic         sw_ref, sw_c_plus, sw_c_minus, busy, done;
  logic [1:0]   status;
`ifdef COL_PULSE_REPEAT_EN
  logic [3:0]   cmd_reps;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Packed observation: {ready, busy, done, status[1:0], minus, plus, ref}
  logic [7:0] obs   [0:MAXC];
  logic [7:0] exp_v [0:MAXC];

  col_pulse_seq #(.W(W), .PRE_CYC(PRE), .DEAD_CYC(DEAD)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_width  (cmd_width),
`ifdef COL_PULSE_REPEAT_EN
    .cmd_reps   (cmd_reps),
`endif
    .abort      (abort),
    .sw_ref     (sw_ref),
    .sw_c_plus  (sw_c_plus),
    .sw_c_minus (sw_c_minus),
    .busy       (busy),
    .done       (done),
    .status     (status)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Switch safety: one-hot-or-zero, and at least DEAD all-low cycles before any switch rises again.
  bit         mon_en  = 1'b0;
  bit         seen_hi = 1'b0;
  logic [2:0] prev_sw = 3'b000;
  int         low_run = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2:0] sw;
      sw = {sw_c_minus, sw_c_plus, sw_ref};
      n_tests++;
      assert ($onehot0(sw)
              && !((sw != 3'b000) && (prev_sw != 3'b000) && (sw != prev_sw))
              && !((sw != 3'b000) && (prev_sw == 3'b000) && seen_hi && (low_run < DEAD)))
      else begin
        n_fail++;
        $display("FAIL switch_guard t=%0t sw=%b prev=%b low_run=%0d required onehot0 and >=%0d low cycles",
                 $time, sw, prev_sw, low_run, DEAD);
      end
      if (sw == 3'b000) low_run++;
      else begin
        low_run = 0;
        seen_hi = 1'b1;
      end
      prev_sw = sw;
    end
  end

  // Expected per-cycle trace after acceptance built from the phase rules; returns the done cycle index.
  function automatic int model(input logic [1:0] op, input logic [W-1:0] wd, input int reps, input int abort_at);
    int         ph[$];
    logic [2:0] sq[$];
    int         eff;
    int         len;
    logic [2:0] osw;
    logic [1:0] st;
    eff = (wd == '0) ? 1 : int'(wd);
    osw = (op == 2'b01) ? 3'b010 : (op == 2'b10) ? 3'b100 : 3'b001;
    st  = 2'b00;
    if (op == 2'b11) st = 2'b10;
    else begin
      for (int r = 0; r <= reps; r++) begin
        if (op != 2'b00) for (int i = 0; i < PRE; i++) begin ph.push_back(1); sq.push_back(3'b001); end
        for (int i = 0; i < DEAD; i++) begin ph.push_back(2); sq.push_back(3'b000); end
        for (int i = 0; i < eff;  i++) begin ph.push_back(3); sq.push_back(osw);    end
        for (int i = 0; i < DEAD; i++) begin ph.push_back(4); sq.push_back(3'b000); end
      end
    end
    if (abort_at >= 1 && abort_at <= ph.size() && ph[abort_at-1] inside {1, 2, 3}) begin
      while (ph.size() > abort_at) begin
        ph.delete(ph.size() - 1);
        sq.delete(sq.size() - 1);
      end
      for (int i = 0; i < DEAD; i++) begin ph.push_back(4); sq.push_back(3'b000); end
      st = 2'b01;
    end
    len = sq.size() + 1;
    for (int n = 1; n < len; n++) exp_v[n] = {1'b0, 1'b1, 1'b0, 2'b00, sq[n-1]};
    exp_v[len]     = {1'b0, 1'b1, 1'b1, st, 3'b000};
    exp_v[len + 1] = {1'b1, 1'b0, 1'b0, 2'b00, 3'b000};
    return len;
  endfunction

  // Issue one command and record ncyc cycles of outputs; abort is raised during cycle abort_at.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] wd, input int reps, input int abort_at, input int ncyc);
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_width = wd;
`ifdef COL_PULSE_REPEAT_EN
    cmd_reps  = 4'(reps);
`endif
    abort     = (abort_at == 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_width = W'($urandom);
    for (int n = 1; n <= ncyc; n++) begin
      obs[n] = {cmd_ready, busy, done, status, sw_c_minus, sw_c_plus, sw_ref};
      abort  = (n == abort_at);
      @(posedge clk);
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_width = '0;
    abort = 1'b0;
`ifdef COL_PULSE_REPEAT_EN
    cmd_reps = 4'd0;
`endif
    repeat (2) @(negedge clk);
    n_tests++;
    if ({cmd_ready, busy, done, status, sw_c_minus, sw_c_plus, sw_ref} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=10000000",
               {cmd_ready, busy, done, status, sw_c_minus, sw_c_plus, sw_ref});
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_set;
    int len;
    len = model(2'b01, 8'd5, 0, -1);
    issue(2'b01, 8'd5, 0, -1, len + 1);
    for (int n = 1; n <= len + 1; n++) begin
      logic [7:0] m;
      m = exp_v[n][5] ? 8'hFF : 8'hE7;
      n_tests++;
      if ((obs[n] & m) !== (exp_v[n] & m)) begin
        n_fail++;
        $display("FAIL set_trace cyc=%0d got=%b want=%b", n, obs[n], exp_v[n]);
      end
    end
    n_tests++;
    if (obs[14] !== 8'b0110_0000) begin
      n_fail++;
      $display("FAIL set_done_cycle14 got=%b want=01100000", obs[14]);
    end
  endtask

  task automatic test_read;
    int len;
    len = model(2'b00, 8'd0, 0, -1);
    issue(2'b00, 8'd0, 0, -1, len + 1);
    for (int n = 1; n <= len + 1; n++) begin
      logic [7:0] m;
      m = exp_v[n][5] ? 8'hFF : 8'hE7;
      n_tests++;
      if ((obs[n] & m) !== (exp_v[n] & m)) begin
        n_fail++;
        $display("FAIL read_trace cyc=%0d got=%b want=%b", n, obs[n], exp_v[n]);
      end
    end
    n_tests++;
    if (obs[3][2:0] !== 3'b001 || obs[4][2:0] !== 3'b000 || obs[6] !== 8'b0110_0000) begin
      n_fail++;
      $display("FAIL read_w0_pulse got c3=%b c4=%b c6=%b want sw 001,000 then done ok",
               obs[3][2:0], obs[4][2:0], obs[6]);
    end
  endtask

  task automatic test_illegal;
    issue(2'b11, 8'd7, 0, -1, 2);
    n_tests++;
    if (obs[1] !== 8'b0111_0000 || obs[2][7] !== 1'b1 || obs[2][2:0] !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_op got c1=%b c2=%b want c1=01110000 c2 ready=1 sw=000", obs[1], obs[2]);
    end
  endtask

  task automatic test_abort;
    int len;
    len = model(2'b10, 8'd20, 0, 9);
    issue(2'b10, 8'd20, 0, 9, len + 1);
    for (int n = 1; n <= len + 1; n++) begin
      logic [7:0] m;
      m = exp_v[n][5] ? 8'hFF : 8'hE7;
      n_tests++;
      if ((obs[n] & m) !== (exp_v[n] & m)) begin
        n_fail++;
        $display("FAIL abort_trace cyc=%0d got=%b want=%b", n, obs[n], exp_v[n]);
      end
    end
    n_tests++;
    if (obs[9][2:0] !== 3'b100 || obs[10][2:0] !== 3'b000 || obs[11][2:0] !== 3'b000
        || obs[12] !== 8'b0110_1000) begin
      n_fail++;
      $display("FAIL abort_pulse3 got c9=%b c10=%b c11=%b c12=%b want 100,000,000,01101000",
               obs[9][2:0], obs[10][2:0], obs[11][2:0], obs[12]);
    end
  endtask

  task automatic test_full_width;
    int len;
    len = model(2'b01, 8'hFF, 0, -1);
    issue(2'b01, 8'hFF, 0, -1, len + 1);
    for (int n = 1; n <= len + 1; n++) begin
      logic [7:0] m;
      m = exp_v[n][5] ? 8'hFF : 8'hE7;
      n_tests++;
      if ((obs[n] & m) !== (exp_v[n] & m)) begin
        n_fail++;
        $display("FAIL full_width_trace cyc=%0d got=%b want=%b", n, obs[n], exp_v[n]);
      end
    end
  endtask

  task automatic test_midreset;
    int  k;
    int  n_done;
    logic [1:0] st_seen;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_width = 8'd20;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    n_tests++;
    if (sw_c_minus !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_in_pulse got sw_c_minus=%b want 1", sw_c_minus);
    end
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_width = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({sw_c_minus, sw_c_plus, sw_ref, busy, done} !== 5'b00000) begin
        n_fail++;
        $display("FAIL midreset_outputs i=%0d got sw/busy/done=%b want 00000", i,
                 {sw_c_minus, sw_c_plus, sw_ref, busy, done});
      end
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    n_tests++;
    if ({busy, sw_ref, cmd_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL midreset_accept got busy/ref/ready=%b want 110", {busy, sw_ref, cmd_ready});
    end
    n_done = 0;
    st_seen = 2'b11;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin n_done++; st_seen = status; end
      @(posedge clk); @(negedge clk);
    end
    n_tests++;
    if (n_done != 1 || st_seen !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_followup got dones=%0d status=%b want 1 and 00", n_done, st_seen);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      logic [1:0]   op;
      logic [W-1:0] wd;
      int           reps;
      int           ab;
      int           len;
      op   = 2'($urandom_range(0, 3));
      wd   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 30));
      reps = 0;
`ifdef COL_PULSE_REPEAT_EN
      reps = $urandom_range(0, 3);
`endif
      len = model(op, wd, reps, -1);
      ab  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, len + 1);
      len = model(op, wd, reps, ab);
      issue(op, wd, reps, ab, len + 1);
      for (int n = 1; n <= len + 1; n++) begin
        logic [7:0] m;
        m = exp_v[n][5] ? 8'hFF : 8'hE7;
        n_tests++;
        if ((obs[n] & m) !== (exp_v[n] & m)) begin
          n_fail++;
          $display("FAIL random it=%0d op=%0d w=%0d reps=%0d abort_at=%0d cyc=%0d got=%b want=%b",
                   it, op, wd, reps, ab, n, obs[n], exp_v[n]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_read();
    test_illegal();
    test_abort();
    test_full_width();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
